// File: rtl/uart_cmd_decoder.sv
// Frame decoder: 0x55 ADDR D3 D2 D1 D0 CSUM -> one 32-bit register write strobe.
// Optional feature macro: CMD_CHECKSUM_EN (checksum is verified only when defined).
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_D3,
    S_D2,
    S_D1,
    S_D0,
    S_CSUM
  } state_t;

  localparam logic [7:0]  HEADER       = 8'h55;
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [23:0] timer;
  logic [7:0]  addr_shadow;
  logic [31:0] data_shadow;
  logic        csum_ok;

`ifdef CMD_CHECKSUM_EN
  logic [7:0] csum_acc;
  assign csum_ok = (rx_data == csum_acc);
`else
  assign csum_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      timer       <= '0;
      addr_shadow <= '0;
      data_shadow <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      csum_acc    <= '0;
`endif
    end else begin
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      if (state == S_IDLE) begin
        timer <= '0;
        if (rx_valid && rx_data == HEADER) begin
          state <= S_ADDR;
          busy  <= 1'b1;
`ifdef CMD_CHECKSUM_EN
          csum_acc <= '0;
`endif
        end
      end else if (rx_valid) begin
        // A byte arriving in the expiry cycle takes priority over the timeout.
        timer <= '0;
`ifdef CMD_CHECKSUM_EN
        csum_acc <= csum_acc + rx_data;
`endif
        case (state)
          S_ADDR: begin
            addr_shadow <= rx_data;
            state       <= S_D3;
          end
          S_D3: begin
            data_shadow <= {data_shadow[23:0], rx_data};
            state       <= S_D2;
          end
          S_D2: begin
            data_shadow <= {data_shadow[23:0], rx_data};
            state       <= S_D1;
          end
          S_D1: begin
            data_shadow <= {data_shadow[23:0], rx_data};
            state       <= S_D0;
          end
          S_D0: begin
            data_shadow <= {data_shadow[23:0], rx_data};
            state       <= S_CSUM;
          end
          S_CSUM: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            if (csum_ok) begin
              wr_en   <= 1'b1;
              wr_addr <= addr_shadow;
              wr_data <= data_shadow;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (timer == TIMEOUT_LAST) begin
        state       <= S_IDLE;
        busy        <= 1'b0;
        frame_err   <= 1'b1;
        timer       <= '0;
        addr_shadow <= '0;
        data_shadow <= '0;
      end else begin
        timer <= timer + 24'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Schedule-driven bench: a byte/reset timeline is built up front, a frame-level
// model predicts every cycle's outputs, and the DUT is compared cycle by cycle.
module tb_uart_cmd_decoder;

  localparam int T = 100;
  localparam int N = 16000;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        frame_err;
  logic        busy;

  always #5 clk = ~clk;

  uart_cmd_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  bit          s_valid [N];
  bit          s_reset [N];
  logic [7:0]  s_data  [N];
  bit          e_wr    [N];
  bit          e_err   [N];
  bit          e_busy  [N];
  logic [7:0]  e_addr  [N];
  logic [31:0] e_data  [N];

  int ptr;
  int checks;
  int failures;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input int gap, input logic [7:0] b);
    ptr += gap;
    s_valid[ptr] = 1'b1;
    s_data[ptr]  = b;
    ptr++;
  endtask

  task automatic push_reset(input int len);
    for (int i = 0; i < len; i++) begin
      s_reset[ptr] = 1'b1;
      ptr++;
    end
  endtask

  // long_pos selects one byte whose preceding gap is long_gap (-1: none).
  task automatic send_frame(input int first_gap, input int gmax, input logic [7:0] addr,
                            input logic [31:0] data, input bit bad,
                            input int long_pos, input int long_gap);
    logic [7:0] b [7];
    int g;
    b[0] = 8'h55;
    b[1] = addr;
    b[2] = data[31:24];
    b[3] = data[23:16];
    b[4] = data[15:8];
    b[5] = data[7:0];
    b[6] = 8'((int'(b[1]) + int'(b[2]) + int'(b[3]) + int'(b[4]) + int'(b[5]) + (bad ? 1 : 0)) & 255);
    for (int i = 0; i < 7; i++) begin
      if (i == long_pos) g = long_gap;
      else if (i == 0) g = first_gap;
      else g = $urandom_range(0, gmax);
      push_byte(g, b[i]);
    end
  endtask

  task automatic run_model();
    bit          in_frame = 0;
    int          nbytes = 0;
    int          last = 0;
    logic [7:0]  fb [6];
    logic [7:0]  wa = 0;
    logic [31:0] wd = 0;
    bit          wr, err, ok;
    int          sum;
    for (int k = 0; k < N; k++) begin
      wr  = 0;
      err = 0;
      if (s_reset[k]) begin
        in_frame = 0;
        wa = 0;
        wd = 0;
      end else if (in_frame && !s_valid[k] && (k - last) == T) begin
        err = 1;
        in_frame = 0;
      end else if (s_valid[k]) begin
        if (!in_frame) begin
          if (s_data[k] == 8'h55) begin
            in_frame = 1;
            nbytes = 0;
            last = k;
          end
        end else begin
          fb[nbytes] = s_data[k];
          nbytes++;
          last = k;
          if (nbytes == 6) begin
            in_frame = 0;
            sum = (int'(fb[0]) + int'(fb[1]) + int'(fb[2]) + int'(fb[3]) + int'(fb[4])) % 256;
`ifdef CMD_CHECKSUM_EN
            ok = (sum == int'(fb[5]));
`else
            ok = 1;
`endif
            if (ok) begin
              wr = 1;
              wa = fb[0];
              wd = {fb[1], fb[2], fb[3], fb[4]};
            end else begin
              err = 1;
            end
          end
        end
      end
      e_wr[k]   = wr;
      e_err[k]  = err;
      e_busy[k] = in_frame;
      e_addr[k] = wa;
      e_data[k] = wd;
    end
  endtask

  task automatic build_schedule();
    int r;
    logic [7:0] gb;
    ptr = 0;
    push_reset(3);
    // Directed: good frame, bad checksum.
    send_frame(2, 0, 8'h10, 32'h12345678, 0, -1, 0);
    send_frame(3, 0, 8'h10, 32'h12345678, 1, -1, 0);
    // Timeout after 55 10 12, then a good frame.
    push_byte(2, 8'h55); push_byte(0, 8'h10); push_byte(0, 8'h12);
    send_frame(110, 1, 8'hA5, 32'hDEADBEEF, 0, -1, 0);
    // Garbage then a frame with in-frame 0x55 data.
    push_byte(2, 8'hAA); push_byte(1, 8'h00); push_byte(1, 8'hFF);
    push_byte(1, 8'h55); push_byte(0, 8'h01); push_byte(0, 8'h00); push_byte(0, 8'h00);
    push_byte(0, 8'h00); push_byte(0, 8'h55); push_byte(0, 8'h56);
    // Reset mid-frame, then the rest of the frame must be ignored.
    push_byte(2, 8'h55); push_byte(1, 8'h20); push_byte(1, 8'h01);
    push_reset(2);
    push_byte(1, 8'h02); push_byte(1, 8'h03); push_byte(1, 8'h04); push_byte(1, 8'h11);
    // Byte exactly at expiry is accepted; one cycle later it is too late.
    send_frame(3, 1, 8'h33, 32'h0BADF00D, 0, 3, T - 1);
    send_frame(3, 1, 8'h44, 32'hCAFEF00D, 0, 4, T);
    // Back-to-back frames.
    send_frame(3, 0, 8'h01, 32'h11111111, 0, -1, 0);
    send_frame(0, 0, 8'h02, 32'h22222222, 0, -1, 0);
    // Randomized traffic.
    while (ptr < N - 800) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        gb = 8'($urandom);
        if (gb == 8'h55) gb = 8'h54;
        push_byte($urandom_range(0, 5), gb);
      end else if (r == 1) begin
        send_frame($urandom_range(0, 4), 3, 8'($urandom), $urandom, 0,
                   $urandom_range(1, 6), $urandom_range(T - 2, T + 2));
      end else if (r == 2) begin
        push_byte($urandom_range(0, 3), 8'h55);
        push_byte($urandom_range(0, 3), 8'($urandom));
        push_reset($urandom_range(1, 2));
      end else begin
        send_frame($urandom_range(0, 6), 6, 8'($urandom), $urandom,
                   ($urandom_range(0, 3) == 0), -1, 0);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    build_schedule();
    run_model();
    reset    = s_reset[0];
    rx_valid = s_valid[0];
    rx_data  = s_data[0];
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_value($sformatf("wr_en@%0d", k), 32'(wr_en), 32'(e_wr[k]));
      check_value($sformatf("frame_err@%0d", k), 32'(frame_err), 32'(e_err[k]));
      check_value($sformatf("busy@%0d", k), 32'(busy), 32'(e_busy[k]));
      check_value($sformatf("wr_addr@%0d", k), 32'(wr_addr), 32'(e_addr[k]));
      check_value($sformatf("wr_data@%0d", k), wr_data, e_data[k]);
      check_value($sformatf("exclusive@%0d", k), 32'(wr_en & frame_err), 32'd0);
      if (k + 1 < N) begin
        reset    = s_reset[k + 1];
        rx_valid = s_valid[k + 1];
        rx_data  = s_data[k + 1];
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Frame-level controller sitting directly behind the UART byte receiver in the sweeper/PLL control path. Consumes the receiver's one-byte-per-pulse output, sequences it through a fixed command frame, and issues a single 32-bit register-write strobe (address plus data) toward the sweep/PLL configuration registers. Drops malformed or stalled frames and flags them with an error pulse.

## Interface
**Parameters**
- `TIMEOUT_CYCLES`, default 500_000: inter-byte timeout in `clk` cycles (10 ms at 50 MHz). Legal range 2..16_777_215.

**Ports**
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `rx_data` in 8: received byte from the byte receiver; valid only while `rx_valid`=1.
- `rx_valid` in 1: one-cycle pulse, one per received byte (receiver's done strobe).
- `wr_en` out 1: one-cycle register-write strobe.
- `wr_addr` out 8: register address; holds the last committed value.
- `wr_data` out 32: register data; holds the last committed value.
- `frame_err` out 1: one-cycle pulse on checksum mismatch or timeout.
- `busy` out 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- **Frame format:** 7 bytes in this order: `0x55` header, ADDR, D3, D2, D1, D0, CSUM. D3 is the MSB, so `wr_data` = {D3,D2,D1,D0}.
- **Checksum:** CSUM = (ADDR+D3+D2+D1+D0) mod 256. Accumulated in an 8-bit register with wrap-around.
- **FSM states:** IDLE, ADDR, D3, D2, D1, D0, CSUM.
  - IDLE: on `rx_valid` with `rx_data`=`0x55`, go to ADDR and clear the accumulator. Any other byte is silently ignored, with no error.
  - ADDR through D0: each `rx_valid` latches the byte into the shadow address/data register, adds it to the accumulator, and advances the state.
  - CSUM: on `rx_valid`, compare the byte with the accumulator, then return to IDLE.
    - Match: commit shadow registers to `wr_addr`/`wr_data` and pulse `wr_en`.
    - Mismatch: pulse `frame_err`; outputs are not updated.
- **Header inside a frame:** a `0x55` byte received outside IDLE is treated as data, not as a resync.
- **Timeout counter:** 24 bits.
  - Cleared on every accepted `rx_valid` and while in IDLE.
  - Increments each cycle in non-IDLE states.
  - When it reaches `TIMEOUT_CYCLES-1` with no `rx_valid` that cycle: pulse `frame_err`, return to IDLE, discard the shadow registers.
  - If `rx_valid` coincides with expiry, the byte wins: it is processed normally and the counter clears.
- **Reset (including mid-frame):** state=IDLE; `wr_en`=0, `wr_addr`=0, `wr_data`=0, `frame_err`=0, `busy`=0; counter, accumulator and shadow registers cleared. A partial frame is lost.
- **Output exclusivity:** `wr_en` and `frame_err` are never high in the same cycle.

## Timing
- All outputs are registered.
- **Commit latency:** `wr_en`, `wr_addr`, `wr_data` and `frame_err` update at the first clock edge after the cycle where `rx_valid` carries CSUM. That is, 1 cycle of latency, and the new `wr_addr`/`wr_data` are valid in the same cycle as `wr_en`.
- **Timeout pulse:** `frame_err` is high for exactly one cycle, in the cycle after the counter hits `TIMEOUT_CYCLES-1`.
- **`busy`:** rises the cycle after the header is accepted. Falls the cycle after CSUM is accepted or timeout fires.
- **Back-to-back frames:** a header byte arriving the cycle immediately after the CSUM `rx_valid` is accepted. No dead cycle is required.
- **No backpressure:** `rx_valid` pulses are never stalled. The receiver delivers at most one byte per ~10 bit times.

## Configuration
- **`CMD_CHECKSUM_EN` defined:** CSUM is compared as described; a mismatch gives `frame_err` and no write.
- **`CMD_CHECKSUM_EN` undefined:** the CSUM byte is still required as the 7th byte, but its value is ignored. Every complete frame commits with `wr_en`. `frame_err` fires only on timeout. The accumulator logic is removed.

## Test plan
- **Good frame:** bytes 55 10 12 34 56 78 24 → one `wr_en` pulse 1 cycle after the last `rx_valid`, with `wr_addr`=0x10 and `wr_data`=0x12345678; `frame_err` stays 0; `busy` high from header+1 to CSUM+1.
- **Bad checksum** (macro defined): bytes 55 10 12 34 56 78 25 → `frame_err` pulse, no `wr_en`; `wr_addr`/`wr_data` keep their prior values. With the macro undefined, the same stimulus gives a `wr_en` commit of 0x10/0x12345678.
- **Timeout:** `TIMEOUT_CYCLES`=100; send 55 10 12, then idle 100 cycles → `frame_err` pulse and `busy`=0. A following full good frame then commits normally.
- **Garbage before header:** bytes AA 00 FF, then 55 01 00 00 00 55 56 → no error on the garbage bytes; `wr_addr`=0x01, `wr_data`=0x00000055 (the in-frame 0x55 is treated as data).
- **Reset mid-frame:** assert `reset` after 55 20 01 → all outputs 0 and `busy`=0. The remaining bytes 02 03 04 xx, sent after reset, cause no `wr_en` and no `frame_err`.
- **Boundary cases:**
  - `rx_valid` in the exact expiry cycle is accepted with no error.
  - Back-to-back frames with a header one cycle after CSUM produce two `wr_en` pulses.
